keypad_scan_input: RTL and testbench
====================================

Name: keypad_scan_input

Overview:
Scanned 4x4 matrix keypad reader: the input-side counterpart of the board's multiplexed seven-segment output.
- Drives one active-low column at a time and samples the active-low rows.
- Debounces the result and emits one hex key code per press on a valid/ack handshake.
- Shifts each accepted digit into a 32-bit number register, which can feed the CPU or loop back to the display's 32-bit number input.

Parameters:
SCAN_INTERVAL, 5000, clk cycles each column is driven before the next (>=2)
DEBOUNCE_SCANS, 4, consecutive identical full-scan snapshots needed to accept a press or a release (>=1)
REPEAT_SCANS, 64, full scans between repeat events (used only with KEY_AUTOREPEAT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
col  output  [0:3]  column drive, active-low; one bit low at a time
row  input  [0:3]  row sense, active-low (pulled up off-chip); assumed already synchronised
key_ack  input  1  consumer accepts the pending key_code
clear  input  1  zero the number register
key_code  output  4  hex code of the pressed key
key_valid  output  1  key_code pending; held until acknowledged
overrun  output  1  sticky; a key event arrived while key_valid was high
number  output  32  last eight entered digits, newest in [3:0]

Behaviour:
- Clock and reset: single clock clk; synchronous active-low rst_n, sampled only on the rising edge.
- Reset values: col=4'b1111, key_code=0, key_valid=0, overrun=0, number=0. All counters and the snapshot are zeroed and the FSM enters IDLE. A reset mid-press discards everything, including a pending key.
- Scan sequencer:
  - Slot counter runs 0..SCAN_INTERVAL-1; column index runs 0..3 and wraps.
  - First cycle after reset release: col=4'b0111 (col[0] low), then 1011, 1101, 1110, then back to 0111.
  - One full scan = 4*SCAN_INTERVAL cycles.
- Sampling:
  - Rows are sampled in the last cycle of each slot, giving settle time.
  - The sample goes into the 16-bit snapshot at bits [4*c +: 4] for column c.
  - The snapshot is complete at the end of column 3; that cycle is the "scan done" strobe.
- Key mapping: pressed at row r, column c -> code = {r[1:0], c[1:0]}, i.e. code 4*r+c.
- Snapshot classification:
  - NONE: all ones.
  - SINGLE: exactly one zero bit.
  - MULTI: anything else.
- FSM (advances only on scan done):
  - IDLE: on SINGLE, latch the candidate, set cnt=1, go to DEBOUNCE. Otherwise stay.
  - DEBOUNCE: snapshot equals the candidate -> cnt++. On reaching DEBOUNCE_SCANS, raise a key event and go to HELD. Any other snapshot returns to IDLE. With DEBOUNCE_SCANS=1 the event is raised straight from IDLE.
  - HELD: on NONE go to RELEASE with cnt=1. SINGLE of a different key or MULTI is ignored; no event until all keys are released.
  - RELEASE: NONE -> cnt++; reaching DEBOUNCE_SCANS returns to IDLE. Any non-NONE snapshot returns to HELD.
- Key event (one cycle after the scan-done edge that completes debounce):
  - If key_valid=0: key_code<=code, key_valid<=1, number<={number[27:0],code}.
  - If key_valid=1: code dropped, number unchanged, overrun<=1.
- Handshake:
  - key_valid clears the cycle after key_ack is sampled high while key_valid=1.
  - key_ack with key_valid=0 is ignored.
  - Ack and a new event in the same cycle: the ack is honoured first, and the event loads the new code with no overrun.
- overrun clears only on reset.
- clear: number<=0 next cycle.
  - Clear in the same cycle as an event: clear wins for number (number=0).
  - key_code and key_valid still update normally.

Optional Feature:
KEY_AUTOREPEAT_EN
- Defined: while in HELD, a repeat counter counts scan-done strobes. After REPEAT_SCANS of them it issues a further key event with the held code, under the same rules as a first press (including overrun), then restarts the count. Leaving HELD resets the counter.
- Undefined: no repeat logic is present; exactly one event per debounced press, and REPEAT_SCANS is unused.

Test Plan:
All scenarios use SCAN_INTERVAL=4, DEBOUNCE_SCANS=2.
1. Reset release, no keys -> col sequence 0111,1011,1101,1110 changing every 4 cycles and wrapping; key_valid stays 0, number=0.
2. Hold row[2] low only while col[1] is low, for 3 full scans -> exactly one event: key_code=4'h9, key_valid=1, number=32'h00000009. Ack -> key_valid=0 next cycle.
3. Enter keys 1,2,3 in turn, each pressed, released, and acked -> number=32'h00000123. Assert clear -> number=0 next cycle.
4. Press key 5 but do not ack, release it, then press key 6 -> key_code stays 5, overrun=1, number=32'h00000005.
5. Bounce: a SINGLE snapshot followed by a NONE snapshot, repeated -> no event. Key 3 and key 7 pressed together -> no event. Key 3 held, then key 7 added -> exactly one event, code 3.
6. Reset asserted while in DEBOUNCE and while key_valid=1 -> all outputs return to reset values the next cycle. With KEY_AUTOREPEAT_EN and REPEAT_SCANS=3, holding key A with prompt acks -> events for code A after debounce, then every 3 scans.

Source files
------------

// File: rtl/keypad_scan_input.sv
// keypad_scan_input: scanned 4x4 active-low keypad reader with debounce, valid/ack key
// delivery, overrun flag and a 32-bit shift register of entered hex digits.
// Optional KEY_AUTOREPEAT_EN: re-issue the held key every REPEAT_SCANS full scans.
module keypad_scan_input #(
    parameter int SCAN_INTERVAL  = 5000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [0:3]  col,
    input  logic [0:3]  row,
    input  logic        key_ack,
    input  logic        clear,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        overrun,
    output logic [31:0] number
);
    localparam int SW = $clog2(SCAN_INTERVAL);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    logic          run_q, run_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [15:0]   snap_q, snap_d;
    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   cand_q, cand_d;
    logic          event_q, event_d;
    logic [3:0]    ev_code_q, ev_code_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          overrun_q, overrun_d;
    logic [31:0]   number_q, number_d;
    logic          sample, scan_done, none, single, deb_ev, rep_fire, free;
    logic [15:0]   zeros, code_src;
    logic [3:0]    pos;

    // Column sequencer; each column's rows land in the snapshot on the slot's last cycle
    always_comb begin
        run_d     = 1'b1;
        sample    = run_q && slot_q == SW'(SCAN_INTERVAL - 1);
        slot_d    = (!run_q || sample) ? '0 : slot_q + SW'(1);
        col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
        scan_done = sample && col_idx_q == 2'd3;
        snap_d    = snap_q;
        for (int r = 0; r < 4; r++)
            if (sample) snap_d[{col_idx_q, 2'(r)}] = row[r];
        col = 4'b1111;
        if (run_q) col[col_idx_q] = 1'b0;
    end

    // Snapshot classification and the key code of the single zero bit (index 4*col+row)
    always_comb begin
        zeros    = ~snap_d;
        none     = zeros == 16'h0;
        single   = !none && (zeros & (zeros - 16'd1)) == 16'h0;
        code_src = (st_q == HELD) ? cand_q : snap_d;
        pos      = 4'h0;
        for (int i = 0; i < 16; i++)
            if (!code_src[i]) pos = 4'(i);
        ev_code_d = {pos[1:0], pos[3:2]};
    end

    // Debounce FSM next state, evaluated only on the scan-done strobe
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        cand_d = cand_q;
        if (scan_done) begin
            case (st_q)
                IDLE: if (single) begin
                    cand_d = snap_d;
                    cnt_d  = CW'(1);
                    st_d   = (DEBOUNCE_SCANS == 1) ? HELD : DEBOUNCE;
                end
                DEBOUNCE: begin
                    cnt_d = cnt_q + CW'(1);
                    st_d  = (snap_d != cand_q) ? IDLE : (cnt_d == CW'(DEBOUNCE_SCANS)) ? HELD : DEBOUNCE;
                end
                HELD: if (none) begin
                    cnt_d = CW'(1);
                    st_d  = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                end
                RELEASE: begin
                    cnt_d = cnt_q + CW'(1);
                    st_d  = !none ? HELD : (cnt_d == CW'(DEBOUNCE_SCANS)) ? IDLE : RELEASE;
                end
                default: st_d = IDLE;
            endcase
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_q, rep_d;

    // Repeat counter runs only while the key stays held; wraps when it fires
    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (st_q == HELD && st_d == HELD) begin
            rep_fire = scan_done && rep_q == RW'(REPEAT_SCANS - 1);
            rep_d    = rep_fire ? '0 : rep_q + RW'(scan_done);
        end
    end

    // Repeat counter register
    always_ff @(posedge clk) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    // FSM output: key event when debounce completes (or a repeat fires)
    always_comb begin
        deb_ev = scan_done && ((st_q == IDLE && single && DEBOUNCE_SCANS == 1) ||
                 (st_q == DEBOUNCE && snap_d == cand_q && cnt_q + CW'(1) == CW'(DEBOUNCE_SCANS)));
        event_d = deb_ev || rep_fire;
    end

    // Key delivery: an ack in the same cycle frees the slot for the incoming event
    always_comb begin
        free        = !key_valid_q || key_ack;
        key_code_d  = (event_q && free) ? ev_code_q : key_code_q;
        key_valid_d = event_q || (key_valid_q && !key_ack);
        overrun_d   = overrun_q || (event_q && !free);
        number_d    = clear ? 32'h0 : (event_q && free) ? {number_q[27:0], ev_code_q} : number_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            slot_q      <= '0;
            col_idx_q   <= 2'd0;
            snap_q      <= 16'h0;
            st_q        <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 16'h0;
            event_q     <= 1'b0;
            ev_code_q   <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            number_q    <= 32'h0;
        end else begin
            run_q       <= run_d;
            slot_q      <= slot_d;
            col_idx_q   <= col_idx_d;
            snap_q      <= snap_d;
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            event_q     <= event_d;
            ev_code_q   <= ev_code_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
            number_q    <= number_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;
    assign number    = number_q;
endmodule

// File: tb/tb_keypad_scan_input.sv
// tb_keypad_scan_input: directed bench with a behavioural keypad matrix (SCAN_INTERVAL=4, DEBOUNCE_SCANS=2).
module tb_keypad_scan_input;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:3]  col;
    logic [0:3]  row;
    logic        key_ack = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        overrun;
    logic [31:0] number;
    logic [15:0] keys = 16'h0;
    int          tcnt = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    keypad_scan_input #(.SCAN_INTERVAL(4), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(3)) dut (
        .clk(clk), .rst_n(rst_n), .col(col), .row(row), .key_ack(key_ack), .clear(clear),
        .key_code(key_code), .key_valid(key_valid), .overrun(overrun), .number(number)
    );

    always #5 clk = ~clk;

    // Pressed key at row r, column c (bit 4r+c) pulls row r low while column c is driven low
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
    end

    // Cycles since reset release; a scan starts right after an edge where tcnt%16 becomes 1
    always @(posedge clk) tcnt <= rst_n ? tcnt + 1 : 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        while (tcnt % 16 != 1) @(negedge clk);
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        keys = k;
        repeat (16 * n) @(negedge clk);
    endtask

    task automatic press(input int k, input int n);
        sync();
        hold(16'h1 << k, n);
        hold(16'h0, 3);
    endtask

    task automatic ack();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!key_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!key_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int nev, t_prev;
        logic [3:0] c_exp [5];
        c_exp = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111};
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col), 32'hF);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_number", number, 32'h0);
        rst_n = 1'b1;
        // 1: column walk
        sync();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("col_%0d", i), 32'(col), 32'(c_exp[i]));
            repeat (4) @(negedge clk);
        end
        hold(16'h0, 2);
        check("idle_valid", 32'(key_valid), 32'h0);
        check("idle_number", number, 32'h0);
        // 2: key 9 (row 2, col 1)
        press(9, 3);
        check("k9_code", 32'(key_code), 32'h9);
        check("k9_valid", 32'(key_valid), 32'h1);
        check("k9_number", number, 32'h9);
        ack();
        check("k9_ack", 32'(key_valid), 32'h0);
        ack();
        check("ack_idle", 32'(key_valid), 32'h0);
        // 3: keys 1,2,3 then clear
        do_clear();
        check("clr0", number, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            press(k, 3);
            check($sformatf("k%0d_code", k), 32'(key_code), 32'(k));
            ack();
        end
        check("k123_number", number, 32'h123);
        check("k123_overrun", 32'(overrun), 32'h0);
        do_clear();
        check("clr1", number, 32'h0);
        // 4: overrun
        press(5, 3);
        press(6, 3);
        check("ovr_code", 32'(key_code), 32'h5);
        check("ovr_valid", 32'(key_valid), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_number", number, 32'h5);
        ack();
        // 5: bounce, multi-press, held key plus another
        sync();
        for (int i = 0; i < 3; i++) begin
            hold(16'h0008, 1);
            hold(16'h0000, 1);
        end
        check("bounce_valid", 32'(key_valid), 32'h0);
        sync();
        hold(16'h0088, 3);
        hold(16'h0, 3);
        check("multi_valid", 32'(key_valid), 32'h0);
        sync();
        hold(16'h0008, 3);
        hold(16'h0088, 3);
        hold(16'h0, 3);
        check("k3_code", 32'(key_code), 32'h3);
        check("k3_number", number, 32'h53);
        ack();
        check("k3_single", 32'(key_valid), 32'h0);
        check("sticky_overrun", 32'(overrun), 32'h1);
        // 6: reset while key pending and while debouncing
        press(10, 3);
        check("kA_number", number, 32'h53A);
        sync();
        hold(16'h0800, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_col", 32'(col), 32'hF);
        check("mrst_valid", 32'(key_valid), 32'h0);
        check("mrst_code", 32'(key_code), 32'h0);
        check("mrst_overrun", 32'(overrun), 32'h0);
        check("mrst_number", number, 32'h0);
        keys = 16'h0;
        rst_n = 1'b1;
        hold(16'h0, 3);
        check("post_rst_valid", 32'(key_valid), 32'h0);
`ifdef KEY_AUTOREPEAT_EN
        sync();
        keys = 16'h0400;
        t_prev = 0;
        for (int e = 0; e < 3; e++) begin
            wait_valid($sformatf("rep%0d", e));
            check($sformatf("rep%0d_code", e), 32'(key_code), 32'hA);
            if (e > 0) check($sformatf("rep%0d_gap", e), 32'(tcnt - t_prev), 32'd48);
            t_prev = tcnt;
            ack();
        end
        keys = 16'h0;
        hold(16'h0, 3);
`else
        sync();
        keys = 16'h0400;
        nev = 0;
        for (int i = 0; i < 16 * 8; i++) begin
            if (key_valid && !key_ack) nev++;
            key_ack = key_valid;
            @(negedge clk);
        end
        key_ack = 1'b0;
        keys = 16'h0;
        check("norep_events", 32'(nev), 32'd1);
        check("norep_code", 32'(key_code), 32'hA);
        hold(16'h0, 3);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
